// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame commit path.
// State encoding, tile codes and default grid geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_VBLANK = 2'd1,
        COPY        = 2'd2,
        ACK         = 2'd3
    } commit_state_t;

    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BDR = 8'd2;
    localparam logic [7:0] BLK = 8'd3;
    localparam logic [7:0] GND = 8'd4;
    localparam logic [7:0] TKN = 8'd5;

    localparam int DEF_SCREEN_HEIGHT = 480;
    localparam int DEF_TILE_ROWS     = 12;
    localparam int DEF_TILE_COLS     = 17;

endpackage

// File: rtl/tile_staging_buffer.sv
// Staging tile grid written by game logic and read back
// one tile per cycle by the commit copy.
module tile_staging_buffer #(
    parameter int TILE_ROWS = vga_pkg::DEF_TILE_ROWS,
    parameter int TILE_COLS = vga_pkg::DEF_TILE_COLS,
    parameter int SKY       = int'(vga_pkg::SKY),
    parameter int IW        = 8
) (
    input  logic          vga_clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [3:0]    wr_row,
    input  logic [4:0]    wr_col,
    input  logic [7:0]    wr_data,
    input  logic [IW-1:0] rd_index,
    output logic [7:0]    rd_data
);
    localparam int N = TILE_ROWS * TILE_COLS;

    logic [7:0]    mem [N];
    logic          in_range;
    logic [IW-1:0] wr_index;

    assign in_range = (32'(wr_row) < 32'(TILE_ROWS)) &&
                      (32'(wr_col) < 32'(TILE_COLS));
    assign wr_index = IW'(32'(wr_row) * 32'(TILE_COLS) + 32'(wr_col));
    assign rd_data  = mem[rd_index];

    // Out-of-range writes are dropped so they never alias onto a real tile.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= 8'(SKY);
            end
        end else if (wr_en && in_range) begin
            mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/vga_frame_commit_scheduler.sv
// Commits staged background tiles and Mario position to the
// drawer-facing state only during vertical blank.
module vga_frame_commit_scheduler #(
    parameter int SCREEN_HEIGHT = vga_pkg::DEF_SCREEN_HEIGHT,
    parameter int TILE_ROWS     = vga_pkg::DEF_TILE_ROWS,
    parameter int TILE_COLS     = vga_pkg::DEF_TILE_COLS,
    parameter int SKY           = int'(vga_pkg::SKY)
) (
    input  logic                                 vga_clock,
    input  logic                                 reset,
    input  logic signed [31:0]                   row,
    input  logic                                 tile_wr_valid,
    output logic                                 tile_wr_ready,
    input  logic [3:0]                           tile_wr_row,
    input  logic [4:0]                           tile_wr_col,
    input  logic [7:0]                           tile_wr_data,
    input  logic                                 mario_wr_valid,
    input  logic signed [31:0]                   mario_wr_x,
    input  logic signed [31:0]                   mario_wr_y,
    input  logic                                 commit_req,
    output logic                                 commit_ack,
    output logic signed [31:0]                   mario_x,
    output logic signed [31:0]                   mario_y,
    output logic [TILE_ROWS-1:0][TILE_COLS-1:0][7:0] background,
    output logic [15:0]                          frame_count
);
    import vga_pkg::*;

    localparam int N  = TILE_ROWS * TILE_COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    commit_state_t      state;
    logic [IW-1:0]      copy_index;
    logic               vblank_q;
    logic               in_vblank;
    logic               vblank_rise;
    logic signed [31:0] staged_x;
    logic signed [31:0] staged_y;
    logic [7:0]         staged_tile;

    assign in_vblank     = row >= SCREEN_HEIGHT;
    assign vblank_rise   = in_vblank && !vblank_q;
    assign tile_wr_ready = state != COPY;
    assign commit_ack    = state == ACK;

    tile_staging_buffer #(
        .TILE_ROWS (TILE_ROWS),
        .TILE_COLS (TILE_COLS),
        .SKY       (SKY),
        .IW        (IW)
    ) u_staging (
        .vga_clock (vga_clock),
        .reset     (reset),
        .wr_en     (tile_wr_valid && tile_wr_ready),
        .wr_row    (tile_wr_row),
        .wr_col    (tile_wr_col),
        .wr_data   (tile_wr_data),
        .rd_index  (copy_index),
        .rd_data   (staged_tile)
    );

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            vblank_q    <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            vblank_q <= in_vblank;
            if (vblank_rise) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // A dropped request aborts only while still waiting for vblank.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            copy_index <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (commit_req) state <= WAIT_VBLANK;
                end
                WAIT_VBLANK: begin
                    if (!commit_req)      state <= IDLE;
                    else if (vblank_rise) state <= COPY;
                end
                COPY: begin
                    if (copy_index == LAST) begin
                        copy_index <= '0;
                        state      <= ACK;
                    end else begin
                        copy_index <= copy_index + 1'b1;
                    end
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            staged_x <= '0;
            staged_y <= '0;
        end else if (mario_wr_valid && state != COPY) begin
            staged_x <= mario_wr_x;
            staged_y <= mario_wr_y;
        end
    end

    // Committed state moves only in COPY, never mid-frame.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            background <= {N{8'(SKY)}};
            mario_x    <= '0;
            mario_y    <= '0;
        end else if (state == COPY) begin
            for (int r = 0; r < TILE_ROWS; r++) begin
                for (int c = 0; c < TILE_COLS; c++) begin
                    if (copy_index == IW'(r * TILE_COLS + c)) begin
                        background[r][c] <= staged_tile;
                    end
                end
            end
            if (copy_index == '0) begin
                mario_x <= staged_x;
                mario_y <= staged_y;
            end
        end
    end

endmodule

// File: doc/vga_frame_commit_scheduler.md
VGA_FRAME_COMMIT_SCHEDULER -- requirements
Module: vga_frame_commit_scheduler

Interface
REQ-001 The block SHALL have parameter SCREEN_HEIGHT, default 480: first non-visible row; vblank is row >= SCREEN_HEIGHT.
REQ-002 The block SHALL have parameter TILE_ROWS, default 12: background rows.
REQ-003 The block SHALL have parameter TILE_COLS, default 17: background columns.
REQ-004 The block SHALL have parameter SKY, default 1: tile reset value.
REQ-005 The block SHALL have port vga_clock, input, 1: sole clock.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port row, input, int: current VGA row from the signal generator.
REQ-008 The block SHALL have ports tile_wr_valid (in, 1), tile_wr_ready (out, 1), tile_wr_row (in, 4), tile_wr_col (in, 5), tile_wr_data (in, byte): staging tile write handshake.
REQ-009 The block SHALL have ports mario_wr_valid (in, 1), mario_wr_x (in, int), mario_wr_y (in, int): staging Mario position write.
REQ-010 The block SHALL have ports commit_req (in, 1) and commit_ack (out, 1): commit handshake with game logic.
REQ-011 The block SHALL have outputs mario_x, mario_y (int) and background (byte [TILE_ROWS-1:0][TILE_COLS-1:0]): committed state feeding the drawer.
REQ-012 The block SHALL have output frame_count, 16 bits: vblank-entry counter.

Function
REQ-013 States SHALL be IDLE, WAIT_VBLANK, COPY and ACK.
REQ-014 vblank_rise SHALL be the registered row >= SCREEN_HEIGHT going 0 -> 1.
REQ-015 frame_count SHALL increment by 1 on every vblank_rise and wrap from 0xFFFF to 0.
REQ-016 tile_wr_ready SHALL be combinational and high in every state except COPY.
REQ-017 A tile write accepted (valid and ready) with row < TILE_ROWS and col < TILE_COLS SHALL update the staging tile on the next edge.
REQ-018 A tile write accepted with out-of-range coordinates SHALL be dropped, with no state change.
REQ-019 mario_wr_valid SHALL update the staging Mario position in any state except COPY; in COPY it SHALL be ignored.
REQ-020 IDLE SHALL move to WAIT_VBLANK when commit_req=1.
REQ-021 WAIT_VBLANK SHALL move to COPY on vblank_rise only; a request raised mid-vblank SHALL wait for the next vblank_rise.
REQ-022 COPY SHALL copy one staging tile per cycle into background, row-major, index 0 to TILE_ROWS*TILE_COLS-1 (204 cycles at default).
REQ-023 COPY SHALL copy the staging Mario position into mario_x and mario_y in the first COPY cycle.
REQ-024 After the last tile, COPY SHALL move to ACK.
REQ-025 ACK SHALL assert commit_ack for exactly one cycle, then move to IDLE.
REQ-026 A commit_req still high in IDLE after ACK SHALL start a new commit.
REQ-027 A tile write accepted in the same cycle as vblank_rise SHALL be included in that commit.
REQ-028 Dropping commit_req during WAIT_VBLANK SHALL return the FSM to IDLE; dropping it during COPY SHALL NOT abort the copy.
REQ-029 The committed outputs SHALL change only in COPY, so the drawer never sees a partial update during visible rows.
REQ-030 The tile index counter SHALL be sized to ceil(log2(TILE_ROWS*TILE_COLS)) bits and SHALL NOT wrap within COPY.

Reset
REQ-031 Asserting reset SHALL immediately force: state IDLE, tile index 0, commit_ack 0, frame_count 0, mario_x/mario_y 0, staging and committed tiles SKY, staging Mario 0, vblank history 0.
REQ-032 Reset asserted mid-COPY SHALL discard the partial copy, with no commit_ack.
REQ-033 Deassertion SHALL take effect on the next vga_clock edge.

Structure
REQ-034 The state enum, SKY/BDR/BLK/GND/TKN tile codes and default grid dimensions SHALL live in shared package vga_pkg.
REQ-035 Staging storage SHALL be sub-module tile_staging_buffer, containing the write port plus the indexed read port used by COPY.

Verification
REQ-036 Reset mid-COPY at tile 100 -> all outputs at reset values, no commit_ack, tile_wr_ready=1 next cycle.
REQ-037 Write tile (2,5)=3, Mario (120,300), commit_req=1 at row 100 -> no output change until row 480; background[2][5]=3 and mario=(120,300) after copy; commit_ack pulses once, 205 cycles after vblank_rise.
REQ-038 commit_req raised at row 490 -> copy starts at the following frame's vblank_rise.
REQ-039 tile_wr_valid held through COPY -> tile_wr_ready=0 for all 204 cycles and the write lands only after ACK.
REQ-040 Write to (12,0) and (0,17) -> dropped; staging and committed grids unchanged.
REQ-041 frame_count preloaded near 0xFFFF via 65536 vblanks (or forced) -> wraps to 0.
